// File: rtl/font_pkg.sv
// Shared font definitions: default glyph geometry, glyph codes, the streamer FSM
// state type and the built-in digit/score glyph image (rows 2..11 carry ink).
package font_pkg;

  localparam int NUM_GLYPHS_DEF = 16;
  localparam int GLYPH_H_DEF    = 16;
  localparam int GLYPH_W_DEF    = 8;

  localparam logic [3:0] CHAR_C     = 4'hA;
  localparam logic [3:0] CHAR_E     = 4'hB;
  localparam logic [3:0] CHAR_O     = 4'hC;
  localparam logic [3:0] CHAR_R     = 4'hD;
  localparam logic [3:0] CHAR_S     = 4'hE;
  localparam logic [3:0] CHAR_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  // Glyph bitmaps hold rows 2..11 only, top row in the most significant byte.
  function automatic logic [7:0] font_row(input logic [3:0] code, input logic [3:0] row);
    logic [79:0] g;
    logic [79:0] sh;
    case (code)
      4'h0:       g = 80'h7CC6C6CED6E6C6C6C67C;
      4'h1:       g = 80'h1838781818181818187E;
      4'h2:       g = 80'h7CC6060C183060C0C6FE;
      4'h3:       g = 80'h7CC606063C060606C67C;
      4'h4:       g = 80'h0C1C3C6CCCFE0C0C0C1E;
      4'h5:       g = 80'hFEC0C0FC06060606C67C;
      4'h6:       g = 80'h3860C0C0FCC6C6C6C67C;
      4'h7:       g = 80'hFEC6060C183030303030;
      4'h8:       g = 80'h7CC6C6C67CC6C6C6C67C;
      4'h9:       g = 80'h7CC6C6C67E0606060C78;
      CHAR_C:     g = 80'h3C66C2C0C0C0C0C2663C;
      CHAR_E:     g = 80'hFE6662687868606266FE;
      CHAR_O:     g = 80'h7CC6C6C6C6C6C6C6C67C;
      CHAR_R:     g = 80'hFC6666667C6C666666E6;
      CHAR_S:     g = 80'h7CC6C660380C06C6C67C;
      CHAR_BLANK: g = '0;
      default:    g = '0;
    endcase
    font_row = '0;
    if (row >= 4'd2 && row <= 4'd11) begin
      sh = g >> (8 * (11 - int'(row)));
      font_row = sh[7:0];
    end
  endfunction

endpackage

// File: rtl/font_rom_sync.sv
// Registered-read glyph ROM; data appears the cycle after an enabled address.
// Only the built-in digit/score image is baked in; any other FONT_FILE name reads as blank.
module font_rom_sync
  import font_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 8,
  parameter int ROWS      = 16,
  parameter     FONT_FILE = "font_digits.mem",
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] rd_dat
);

  localparam bit BUILTIN = (FONT_FILE == "font_digits.mem");

  function automatic logic [WIDTH-1:0] image_word(input logic [AW-1:0] a);
    int idx;
    int code;
    int row;
    idx  = int'(a);
    code = idx / ROWS;
    row  = idx % ROWS;
    image_word = '0;
    if (BUILTIN && idx < DEPTH && code < 16 && row < 16)
      image_word = WIDTH'(font_row(4'(code), 4'(row)));
  endfunction

  always_ff @(posedge clk) begin
    if (en)
      rd_dat <= image_word(addr);
  end

endmodule

// File: rtl/font_glyph_streamer.sv
// Glyph row streamer: one (code,row) request -> GLYPH_W*SCALE pixel beats, MSB first.
// Latency: first pixel beat two cycles after the request handshake.
// Backpressure: beats hold while pix_ready=0; req_ready only in IDLE. Option: FONT_UNDERLINE_EN.
module font_glyph_streamer
  import font_pkg::*;
#(
  parameter int NUM_GLYPHS = NUM_GLYPHS_DEF,
  parameter int GLYPH_H    = GLYPH_H_DEF,
  parameter int GLYPH_W    = GLYPH_W_DEF,
  parameter int SCALE      = 1,
  parameter     FONT_FILE  = "font_digits.mem",
  localparam int CODE_W    = $clog2(NUM_GLYPHS),
  localparam int ROW_W     = $clog2(GLYPH_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_char,
  input  logic [ROW_W-1:0]  req_row,
`ifdef FONT_UNDERLINE_EN
  input  logic              req_uline,
`endif
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_on,
  output logic              pix_last
);

  localparam int DEPTH  = NUM_GLYPHS * GLYPH_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int COL_W  = $clog2(GLYPH_W);
  localparam int REP_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [CODE_W:0] CODE_LIM = (CODE_W+1)'(NUM_GLYPHS);
  localparam logic [ROW_W:0]  ROW_LIM  = (ROW_W+1)'(GLYPH_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GLYPH_W - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);

  state_t state, state_nxt;

  logic               req_fire;
  logic               in_range;
  logic               rom_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [GLYPH_W-1:0] rom_dat;
  logic [GLYPH_W-1:0] load_row;
  logic [GLYPH_W-1:0] shift_reg;
  logic [COL_W-1:0]   col_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic               blank_q;
  logic               beat_acc;
  logic               last_beat;

  assign req_ready = (state == IDLE) && !Reset;
  assign req_fire  = req_valid && req_ready;
  assign in_range  = ({1'b0, req_char} < CODE_LIM) && ({1'b0, req_row} < ROW_LIM);

  // The ROM is addressed straight from the request so its data is ready during FETCH.
  assign rom_en   = req_fire && in_range;
  assign rom_addr = ADDR_W'(req_char) * ADDR_W'(GLYPH_H) + ADDR_W'(req_row);

  font_rom_sync #(
    .DEPTH    (DEPTH),
    .WIDTH    (GLYPH_W),
    .ROWS     (GLYPH_H),
    .FONT_FILE(FONT_FILE)
  ) u_rom (
    .clk   (Clk),
    .en    (rom_en),
    .addr  (rom_addr),
    .rd_dat(rom_dat)
  );

`ifdef FONT_UNDERLINE_EN
  logic uline_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      uline_q <= 1'b0;
    else if (req_fire)
      uline_q <= req_uline && (req_row == ROW_W'(GLYPH_H - 3));
  end

  assign load_row = blank_q ? '0 : (uline_q ? '1 : rom_dat);
`else
  assign load_row = blank_q ? '0 : rom_dat;
`endif

  assign beat_acc  = (state == SHIFT) && pix_ready;
  assign last_beat = (col_cnt == COL_LAST) && (rep_cnt == REP_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_valid = 1'b0;
    pix_on    = 1'b0;
    pix_last  = 1'b0;
    case (state)
      IDLE:  if (req_fire) state_nxt = FETCH;
      FETCH: state_nxt = SHIFT;
      SHIFT: begin
        pix_valid = 1'b1;
        pix_on    = shift_reg[GLYPH_W-1];
        pix_last  = last_beat;
        if (beat_acc && last_beat)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift_reg <= '0;
      col_cnt   <= '0;
      rep_cnt   <= '0;
      blank_q   <= 1'b0;
    end else begin
      if (req_fire)
        blank_q <= !in_range;
      if (state == FETCH) begin
        shift_reg <= load_row;
        col_cnt   <= '0;
        rep_cnt   <= '0;
      end else if (beat_acc) begin
        if (rep_cnt != REP_LAST) begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end else begin
          rep_cnt   <= '0;
          shift_reg <= {shift_reg[GLYPH_W-2:0], 1'b0};
          col_cnt   <= col_cnt + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/font_glyph_streamer.md
Name: font_glyph_streamer

Overview:
Parametrised glyph pixel engine for the on-screen text and score display. It accepts a (character code, glyph row) request through a valid/ready handshake and reads the glyph row from a synchronous font ROM. It then streams that row out one pixel per accepted beat, MSB (leftmost) first, repeating each pixel SCALE times for horizontal magnification. It sits between the text/score layout logic and the VGA colour mapper.

Parameters:
NUM_GLYPHS, 16, number of glyphs in the ROM; CODE_W = $clog2(NUM_GLYPHS).
GLYPH_H, 16, rows per glyph; ROW_W = $clog2(GLYPH_H).
GLYPH_W, 8, pixels per glyph row (ROM data width).
SCALE, 1, horizontal repeat count per pixel (1..8).
FONT_FILE, "font_digits.mem", $readmemb image, NUM_GLYPHS*GLYPH_H words.

Ports:
Clk        in   1        system clock
Reset      in   1        asynchronous, active-high reset
req_valid  in   1        request present
req_ready  out  1        engine can accept a request
req_char   in   CODE_W   glyph code
req_row    in   ROW_W    glyph row index
pix_valid  out  1        pixel beat present
pix_ready  in   1        consumer accepts the beat
pix_on     out  1        1 = foreground pixel
pix_last   out  1        final beat of the row (column GLYPH_W-1, repeat SCALE-1)

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high: on assertion, FSM goes to IDLE immediately, req_ready=0 for that cycle, and pix_valid=pix_on=pix_last=0.
- ROM address = req_char*GLYPH_H + req_row. Read data is registered, so it is available one cycle after the address.
- ROM image: codes 0x0-0x9 are digits 0-9; 0xA 'C', 0xB 'E', 0xC 'O', 0xD 'R', 0xE 'S', 0xF blank. Rows 0, 1 and 12-15 of every glyph are 0.
- Request handshake fires when req_valid && req_ready. The engine latches the code and row, then goes IDLE -> FETCH.
- FETCH: lasts 1 cycle, while the ROM read completes. The registered row is loaded into a GLYPH_W shift register and the FSM goes to SHIFT. col_cnt=0, rep_cnt=0.
- SHIFT: pix_valid=1 and pix_on = shift_reg MSB.
  - The beat advances only when pix_ready=1; outputs hold stable while pix_ready=0.
  - On each accepted beat: if rep_cnt < SCALE-1, increment rep_cnt. Otherwise clear rep_cnt, shift left by one and increment col_cnt.
  - pix_last=1 only when col_cnt==GLYPH_W-1 and rep_cnt==SCALE-1.
  - When the last beat is accepted, the FSM goes to IDLE.
- req_ready=1 only in IDLE, so requests are never overlapped.
- Latency: request accepted in cycle t gives the first pix_valid in cycle t+2. A full row takes GLYPH_W*SCALE accepted beats.
- Out-of-range inputs: req_char >= NUM_GLYPHS, or req_row >= GLYPH_H (possible when the depth is not a power of two), streams a blank row (all pix_on=0). There is no ROM read outside the array.
- Simultaneous events:
  - req_valid held high during SHIFT is ignored until IDLE.
  - pix_ready low on the last beat holds pix_last high until it is accepted.
- Reset mid-row: the stream is abandoned with no partial completion, and the next request restarts at column 0.

Optional Feature:
FONT_UNDERLINE_EN. When defined:
- Adds input req_uline (1 bit), latched with each request.
- If req_uline=1 and the row equals GLYPH_H-3, the shift register loads all ones, drawing an underline under the glyph baseline.

When undefined: the port is absent and rows always come from the ROM.

Decomposition:
- font_pkg holds:
  - default NUM_GLYPHS, GLYPH_H, GLYPH_W
  - glyph code constants CHAR_C=4'hA, CHAR_E, CHAR_O, CHAR_R, CHAR_S, CHAR_BLANK=4'hF
  - enum state_t {IDLE, FETCH, SHIFT}
- One sub-module, font_rom_sync: a registered-read ROM parametrised by depth, width and FONT_FILE. The streamer instantiates it once.

Test Plan:
1. Reset, then req_char=1, req_row=4, SCALE=1, pix_ready=1. Required: first pix_valid 2 cycles after the handshake; pix_on sequence 0,1,1,1,1,0,0,0; pix_last on beat 8; req_ready returns to 1 the next cycle.
2. req_char=2, req_row=11, SCALE=2. Required: 16 beats, pattern 11 11 11 11 11 11 11 00; pix_last only on beat 16.
3. req_char=4, req_row=7, with pix_ready toggled 1,0,0,1,... Required: pix_on/pix_last stable while stalled; output still 1111111 then 0, nothing dropped or duplicated.
4. req_char=0xF at any row, and req_char=3 at row 0. Required: 8 beats with pix_on=0.
5. Assert Reset during beat 3 of req_char=8, req_row=2. Required: outputs 0 immediately. After release, a new request for code 0, row 2 streams 0,1,1,1,1,1,0,0 from column 0.
6. With FONT_UNDERLINE_EN: req_char=5, req_row=13, req_uline=1. Required: 8 beats with pix_on=1. With req_uline=0: all 0.
